// File: rtl/mmu_tblwalk.sv
// Two-level page-table walker: on a TLB miss it reads the L1 and L2 descriptors over a
// pipelined Wishbone master, then installs the translation through the MMU control port.
module mmu_tblwalk #(
    parameter int LGTBL = 6
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_miss,
    input  logic [29:0]      i_miss_addr,
    input  logic [19:0]      i_tbl_base,
    input  logic [11:0]      i_context,
    output logic             o_busy,
    output logic             o_mem_cyc,
    output logic             o_mem_stb,
    output logic [29:0]      o_mem_addr,
    input  logic             i_mem_stall,
    input  logic             i_mem_ack,
    input  logic             i_mem_err,
    input  logic [31:0]      i_mem_data,
    output logic             o_ctl_stb,
    output logic [LGTBL+1:0] o_ctl_addr,
    output logic [31:0]      o_ctl_data,
    input  logic             i_ctl_ack,
    output logic             o_done,
    output logic             o_fault,
    output logic [1:0]       o_fault_code
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L1_REQ  = 3'd1,
        L1_WAIT = 3'd2,
        L2_REQ  = 3'd3,
        L2_WAIT = 3'd4,
        WR_V    = 3'd5,
        WR_P    = 3'd6,
        FIN     = 3'd7
    } state_t;

    state_t           state, state_nxt;
    logic [19:0]      vpage;
    logic [19:0]      tbl_base;
    logic [11:0]      ctx;
    logic [19:0]      l1_page;
    logic [31:0]      l2_word;
    logic [LGTBL-1:0] slot;
    logic             gap;
    logic             start, l1_load, l2_load, slot_inc, flt;
    logic [1:0]       flt_code;
    logic             unused_bits;

    // Page offset bits play no part in the walk.
    assign unused_bits = ^i_miss_addr[9:0];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        o_busy     = (state != IDLE);
        o_mem_cyc  = 1'b0;
        o_mem_stb  = 1'b0;
        o_mem_addr = '0;
        o_ctl_stb  = 1'b0;
        o_ctl_addr = '0;
        o_ctl_data = '0;
        o_done     = 1'b0;
        start      = 1'b0;
        l1_load    = 1'b0;
        l2_load    = 1'b0;
        slot_inc   = 1'b0;
        flt        = 1'b0;
        flt_code   = 2'b00;
        case (state)
            IDLE: begin
                if (i_miss) begin
                    start     = 1'b1;
                    state_nxt = L1_REQ;
                end
            end
            L1_REQ: begin
                o_mem_cyc  = 1'b1;
                o_mem_stb  = 1'b1;
                o_mem_addr = {tbl_base, vpage[19:10]};
                if (i_mem_err) begin
                    flt       = 1'b1;
                    flt_code  = 2'b01;
                    state_nxt = IDLE;
                end else if (!i_mem_stall) begin
                    state_nxt = L1_WAIT;
                end
            end
            L1_WAIT: begin
                o_mem_cyc  = 1'b1;
                o_mem_addr = {tbl_base, vpage[19:10]};
                if (i_mem_err) begin
                    flt       = 1'b1;
                    flt_code  = 2'b01;
                    state_nxt = IDLE;
                end else if (i_mem_ack) begin
                    if (!i_mem_data[0]) begin
                        flt       = 1'b1;
                        flt_code  = 2'b10;
                        state_nxt = IDLE;
                    end else begin
                        l1_load   = 1'b1;
                        state_nxt = L2_REQ;
                    end
                end
            end
            L2_REQ: begin
                // First cycle here is the idle gap that ends the L1 bus cycle.
                if (!gap) begin
                    o_mem_cyc  = 1'b1;
                    o_mem_stb  = 1'b1;
                    o_mem_addr = {l1_page, vpage[9:0]};
                    if (i_mem_err) begin
                        flt       = 1'b1;
                        flt_code  = 2'b01;
                        state_nxt = IDLE;
                    end else if (!i_mem_stall) begin
                        state_nxt = L2_WAIT;
                    end
                end
            end
            L2_WAIT: begin
                o_mem_cyc  = 1'b1;
                o_mem_addr = {l1_page, vpage[9:0]};
                if (i_mem_err) begin
                    flt       = 1'b1;
                    flt_code  = 2'b01;
                    state_nxt = IDLE;
                end else if (i_mem_ack) begin
                    if (!i_mem_data[0]) begin
                        flt       = 1'b1;
                        flt_code  = 2'b11;
                        state_nxt = IDLE;
                    end else begin
                        l2_load   = 1'b1;
                        state_nxt = WR_V;
                    end
                end
            end
            WR_V: begin
                o_ctl_stb  = 1'b1;
                o_ctl_addr = {1'b1, slot, 1'b0};
                o_ctl_data = {vpage, l2_word[11:0]};
                if (i_ctl_ack) state_nxt = WR_P;
            end
            WR_P: begin
                o_ctl_stb  = 1'b1;
                o_ctl_addr = {1'b1, slot, 1'b1};
                o_ctl_data = {l2_word[31:12], ctx};
                if (i_ctl_ack) begin
                    slot_inc  = 1'b1;
                    state_nxt = FIN;
                end
            end
            FIN: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vpage        <= '0;
            tbl_base     <= '0;
            ctx          <= '0;
            l1_page      <= '0;
            l2_word      <= '0;
            slot         <= '0;
            gap          <= 1'b0;
            o_fault      <= 1'b0;
            o_fault_code <= 2'b00;
        end else begin
            gap     <= l1_load;
            o_fault <= flt;
            if (start) begin
                vpage        <= i_miss_addr[29:10];
                tbl_base     <= i_tbl_base;
                ctx          <= i_context;
                o_fault_code <= 2'b00;
            end
            if (flt)      o_fault_code <= flt_code;
            if (l1_load)  l1_page      <= i_mem_data[31:12];
            if (l2_load)  l2_word      <= i_mem_data;
            if (slot_inc) slot         <= slot + LGTBL'(1);
        end
    end

endmodule

// File: tb/tb_mmu_tblwalk.sv
// Directed bench for mmu_tblwalk: a one-cycle-latency memory responder and an
// immediate-ack control port, with hand-computed expectations per scenario.
module tb_mmu_tblwalk;
    localparam int LGTBL = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             miss = 1'b0;
    logic [29:0]      miss_addr = '0;
    logic [19:0]      tbl_base = '0;
    logic [11:0]      ctx = '0;
    logic             busy, mem_cyc, mem_stb;
    logic [29:0]      mem_addr;
    logic             mem_stall = 1'b0;
    logic             mem_ack = 1'b0;
    logic             mem_err = 1'b0;
    logic [31:0]      mem_data = '0;
    logic             ctl_stb;
    logic [LGTBL+1:0] ctl_addr;
    logic [31:0]      ctl_data;
    logic             ctl_ack;
    logic             ctl_ack_en = 1'b1;
    logic             done, fault;
    logic [1:0]       fault_code;

    int n_vec = 0;
    int n_err = 0;

    logic [29:0] l1_a = '0, l2_a = '0, err_a = '0;
    logic [31:0] l1_d = '0, l2_d = '0;
    bit          err_en = 1'b0;
    bit          pend = 1'b0, pend_err = 1'b0;
    logic [31:0] pend_data = '0;
    int          stb_cnt = 0, done_cnt = 0, fault_cnt = 0, overlap_cnt = 0, cyc_starts = 0;
    bit          cyc_prev = 1'b0;
    logic [7:0]  wr_a[$];
    logic [31:0] wr_d[$];

    mmu_tblwalk #(.LGTBL(LGTBL)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_miss(miss), .i_miss_addr(miss_addr),
        .i_tbl_base(tbl_base), .i_context(ctx), .o_busy(busy),
        .o_mem_cyc(mem_cyc), .o_mem_stb(mem_stb), .o_mem_addr(mem_addr),
        .i_mem_stall(mem_stall), .i_mem_ack(mem_ack), .i_mem_err(mem_err), .i_mem_data(mem_data),
        .o_ctl_stb(ctl_stb), .o_ctl_addr(ctl_addr), .o_ctl_data(ctl_data), .i_ctl_ack(ctl_ack),
        .o_done(done), .o_fault(fault), .o_fault_code(fault_code)
    );

    always #5 clk = ~clk;
    assign ctl_ack = ctl_ack_en & ctl_stb;

    // Bus observation and the memory responder's accept decision, mid-cycle.
    always @(negedge clk) begin
        pend      = mem_cyc && mem_stb && !mem_stall;
        pend_err  = err_en && (mem_addr == err_a);
        pend_data = (mem_addr == l1_a) ? l1_d : (mem_addr == l2_a) ? l2_d : 32'h0;
        if (pend) stb_cnt++;
        if (done) done_cnt++;
        if (fault) fault_cnt++;
        if (mem_cyc && ctl_stb) overlap_cnt++;
        if (mem_cyc && !cyc_prev) cyc_starts++;
        cyc_prev = mem_cyc;
        if (ctl_stb && ctl_ack) begin
            wr_a.push_back(ctl_addr);
            wr_d.push_back(ctl_data);
        end
    end

    always @(posedge clk) begin
        mem_ack  <= pend && !pend_err;
        mem_err  <= pend && pend_err;
        mem_data <= pend_data;
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic setup_mem(input logic [31:0] d1, input logic [31:0] d2);
        l1_a = 30'h0004000; l1_d = d1;
        l2_a = 30'h0008013; l2_d = d2;
        wr_a.delete();
        wr_d.delete();
    endtask

    // Issues one miss and runs until o_done or o_fault (or a 100-cycle bound).
    task automatic run_walk(input int stall_n, input bit dup_miss, output int lat,
                            output bit saw_done, output bit saw_fault, output bit addr_moved);
        logic [29:0] held;
        held = '0;
        @(posedge clk); #1;
        miss_addr = 30'h0000_4C00; tbl_base = 20'h00010; ctx = 12'h123;
        mem_stall = (stall_n > 0);
        miss = 1'b1;
        lat = 0; saw_done = 1'b0; saw_fault = 1'b0; addr_moved = 1'b0;
        while (lat < 100 && !saw_done && !saw_fault) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) miss = 1'b0;
            if (dup_miss && lat == 2) begin
                miss_addr = 30'h3FFF_FC00; tbl_base = 20'hFFFFF; ctx = 12'hFFF; miss = 1'b1;
            end
            if (dup_miss && lat == 3) miss = 1'b0;
            if (lat == stall_n + 1) mem_stall = 1'b0;
            @(negedge clk);
            if (lat == 1) held = mem_addr;
            else if (lat <= stall_n + 1 && mem_addr !== held) addr_moved = 1'b1;
            saw_done  = done;
            saw_fault = fault;
        end
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({busy, mem_cyc, mem_stb, ctl_stb, done, fault, fault_code} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b want=00000000",
                     {busy, mem_cyc, mem_stb, ctl_stb, done, fault, fault_code});
        end
        n_vec++;
        if ({mem_addr, ctl_addr, ctl_data} !== 70'h0) begin
            n_err++;
            $display("FAIL reset_data got=%h want=0", {mem_addr, ctl_addr, ctl_data});
        end
        #20 rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({busy, mem_cyc, ctl_stb, done, fault} !== 5'b0) begin
            n_err++;
            $display("FAIL post_reset_idle got=%b want=00000", {busy, mem_cyc, ctl_stb, done, fault});
        end
    endtask

    task automatic test_basic_walk();
        int lat; bit d, f, mv; int s0, c0;
        setup_mem(32'h0002_0001, 32'hABCD_E005);
        s0 = stb_cnt; c0 = cyc_starts;
        run_walk(0, 1'b0, lat, d, f, mv);
        @(posedge clk); #1;
        n_vec++;
        if (lat !== 8 || !d) begin n_err++; $display("FAIL basic_latency got=%0d done=%0b want=8 done=1", lat, d); end
        n_vec++;
        if (wr_a.size() !== 2) begin n_err++; $display("FAIL basic_wr_count got=%0d want=2", wr_a.size()); end
        n_vec++;
        if (wr_a[0] !== 8'h80 || wr_d[0] !== 32'h0001_3005) begin
            n_err++; $display("FAIL basic_wr_v got=%h/%h want=80/00013005", wr_a[0], wr_d[0]);
        end
        n_vec++;
        if (wr_a[1] !== 8'h81 || wr_d[1] !== 32'hABCD_E123) begin
            n_err++; $display("FAIL basic_wr_p got=%h/%h want=81/abcde123", wr_a[1], wr_d[1]);
        end
        n_vec++;
        if (stb_cnt - s0 !== 2) begin n_err++; $display("FAIL basic_stb_count got=%0d want=2", stb_cnt - s0); end
        n_vec++;
        if (cyc_starts - c0 !== 2) begin n_err++; $display("FAIL basic_cyc_gap got=%0d want=2", cyc_starts - c0); end
    endtask

    task automatic test_l1_invalid();
        int lat; bit d, f, mv;
        setup_mem(32'h0002_0000, 32'hABCD_E005);
        run_walk(0, 1'b0, lat, d, f, mv);
        n_vec++;
        if (!f || d || fault_code !== 2'b10) begin
            n_err++; $display("FAIL l1_invalid got fault=%0b done=%0b code=%b want 1/0/10", f, d, fault_code);
        end
        n_vec++;
        if (wr_a.size() !== 0) begin n_err++; $display("FAIL l1_invalid_writes got=%0d want=0", wr_a.size()); end
    endtask

    task automatic test_l2_invalid();
        int lat; bit d, f, mv;
        setup_mem(32'h0002_0001, 32'hABCD_E004);
        run_walk(0, 1'b0, lat, d, f, mv);
        n_vec++;
        if (!f || d || fault_code !== 2'b11) begin
            n_err++; $display("FAIL l2_invalid got fault=%0b done=%0b code=%b want 1/0/11", f, d, fault_code);
        end
        n_vec++;
        if (wr_a.size() !== 0) begin n_err++; $display("FAIL l2_invalid_writes got=%0d want=0", wr_a.size()); end
    endtask

    task automatic test_slot_kept();
        int lat; bit d, f, mv;
        setup_mem(32'h0002_0001, 32'hABCD_E005);
        run_walk(0, 1'b0, lat, d, f, mv);
        @(posedge clk); #1;
        n_vec++;
        if (!d || wr_a[0] !== 8'h82 || wr_a[1] !== 8'h83) begin
            n_err++; $display("FAIL slot_kept got done=%0b addr=%h/%h want 1 82/83", d, wr_a[0], wr_a[1]);
        end
        n_vec++;
        if (fault_code !== 2'b00) begin n_err++; $display("FAIL code_cleared got=%b want=00", fault_code); end
    endtask

    task automatic test_bus_error();
        int lat; bit d, f, mv; int f0;
        setup_mem(32'h0002_0001, 32'hABCD_E005);
        err_a = 30'h0008013; err_en = 1'b1;
        f0 = fault_cnt;
        run_walk(0, 1'b0, lat, d, f, mv);
        n_vec++;
        if (!f || mem_cyc !== 1'b0 || fault_code !== 2'b01) begin
            n_err++; $display("FAIL bus_error got fault=%0b cyc=%0b code=%b want 1/0/01", f, mem_cyc, fault_code);
        end
        err_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (fault_cnt - f0 !== 1 || wr_a.size() !== 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL bus_error_after got pulses=%0d writes=%0d busy=%0b want 1/0/0",
                              fault_cnt - f0, wr_a.size(), busy);
        end
    endtask

    task automatic test_stall_and_drop();
        int lat; bit d, f, mv; int s0, d0;
        setup_mem(32'h0002_0001, 32'hABCD_E005);
        s0 = stb_cnt; d0 = done_cnt;
        run_walk(3, 1'b1, lat, d, f, mv);
        n_vec++;
        if (lat !== 11 || !d) begin n_err++; $display("FAIL stall_latency got=%0d done=%0b want=11 done=1", lat, d); end
        n_vec++;
        if (mv !== 1'b0) begin n_err++; $display("FAIL stall_addr_stable got moved=%0b want=0", mv); end
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (stb_cnt - s0 !== 2 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
            n_err++; $display("FAIL stall_dropped_miss got stb=%0d done=%0d busy=%0b want 2/1/0",
                              stb_cnt - s0, done_cnt - d0, busy);
        end
        n_vec++;
        if (wr_a.size() !== 2 || wr_a[0] !== 8'h84 || wr_d[0] !== 32'h0001_3005 || wr_d[1] !== 32'hABCD_E123) begin
            n_err++; $display("FAIL stall_writes got n=%0d %h/%h/%h want 2 84/00013005/abcde123",
                              wr_a.size(), wr_a[0], wr_d[0], wr_d[1]);
        end
    endtask

    task automatic test_reset_mid_walk();
        int lat; bit d, f, mv; int n, d0, f0;
        setup_mem(32'h0002_0001, 32'hABCD_E005);
        ctl_ack_en = 1'b0;
        @(posedge clk); #1;
        miss_addr = 30'h0000_4C00; tbl_base = 20'h00010; ctx = 12'h123; miss = 1'b1;
        @(posedge clk); #1 miss = 1'b0;
        n = 0;
        while (n < 50 && ctl_stb !== 1'b1) begin @(negedge clk); n++; end
        n_vec++;
        if (ctl_stb !== 1'b1) begin n_err++; $display("FAIL rst_reach_wr_v got ctl_stb=%0b want=1", ctl_stb); end
        d0 = done_cnt; f0 = fault_cnt;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ctl_stb, busy, done, fault, mem_cyc} !== 5'b0) begin
            n_err++; $display("FAIL rst_mid_walk got=%b want=00000", {ctl_stb, busy, done, fault, mem_cyc});
        end
        @(posedge clk); #3 rst_n = 1'b1;
        ctl_ack_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (done_cnt !== d0 || fault_cnt !== f0) begin
            n_err++; $display("FAIL rst_no_pulse got done=%0d fault=%0d want 0/0", done_cnt - d0, fault_cnt - f0);
        end
        wr_a.delete(); wr_d.delete();
        run_walk(0, 1'b0, lat, d, f, mv);
        @(posedge clk); #1;
        n_vec++;
        if (!d || lat !== 8 || wr_a[0] !== 8'h80 || wr_d[1] !== 32'hABCD_E123) begin
            n_err++; $display("FAIL rst_fresh_walk got done=%0b lat=%0d addr=%h data=%h want 1/8/80/abcde123",
                              d, lat, wr_a[0], wr_d[1]);
        end
    endtask

    task automatic test_slot_wrap();
        int lat; bit d, f, mv;
        logic [7:0] exp_a;
        apply_reset();
        for (int i = 0; i < 65; i++) begin
            setup_mem(32'h0002_0001, 32'hABCD_E005);
            run_walk(0, 1'b0, lat, d, f, mv);
            exp_a = {1'b1, 6'(i % 64), 1'b0};
            n_vec++;
            if (!d || wr_a[0] !== exp_a) begin
                n_err++; $display("FAIL wrap_walk_%0d got done=%0b addr=%h want 1/%h", i, d, wr_a[0], exp_a);
            end
        end
        n_vec++;
        if (wr_a[1] !== 8'h81) begin n_err++; $display("FAIL wrap_65th_p got=%h want=81", wr_a[1]); end
    endtask

    task automatic test_no_overlap();
        n_vec++;
        if (overlap_cnt !== 0) begin n_err++; $display("FAIL cyc_ctl_overlap got=%0d want=0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_walk();
        test_l1_invalid();
        test_l2_invalid();
        test_slot_kept();
        test_bus_error();
        test_stall_and_drop();
        test_reset_mid_walk();
        test_slot_wrap();
        test_no_overlap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmu_tblwalk.md
MMU_TBLWALK -- requirements
Module: mmu_tblwalk

Interface
REQ-001 SHALL have parameter LGTBL, default 6: log2 of MMU TLB entries; round-robin slot counter width.
REQ-002 SHALL have ports, one per line:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset; one clock, asynchronous, active-low.
- i_miss  in  1  one-cycle TLB-miss pulse from MMU.
- i_miss_addr  in  30  faulting word address; vpage = [29:10].
- i_tbl_base  in  20  physical page of L1 directory.
- i_context  in  12  current context ID.
- o_busy  out  1  walk in progress.
- o_mem_cyc  out  1  WB pipelined master cycle.
- o_mem_stb  out  1  WB strobe.
- o_mem_addr  out  30  WB word address.
- i_mem_stall  in  1  WB stall.
- i_mem_ack  in  1  WB ack.
- i_mem_err  in  1  WB bus error.
- i_mem_data  in  32  WB read data.
- o_ctl_stb  out  1  MMU control-port write strobe.
- o_ctl_addr  out  LGTBL+2  MMU control-port address.
- o_ctl_data  out  32  MMU control-port write data.
- i_ctl_ack  in  1  MMU control-port ack.
- o_done  out  1  one-cycle pulse: TLB entry installed.
- o_fault  out  1  one-cycle pulse: walk failed.
- o_fault_code  out  2  01 bus error, 10 L1 invalid, 11 L2 invalid; held until next walk.

Function
REQ-003 SHALL implement states IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, WR_V, WR_P, FIN.
REQ-004 IDLE: i_miss latches vpage=i_miss_addr[29:10], i_context, i_tbl_base -> L1_REQ next cycle; o_busy=1 in every non-IDLE state.
REQ-005 i_miss while o_busy=1 SHALL be ignored; no queueing.
REQ-006 L1_REQ: o_mem_cyc=o_mem_stb=1, o_mem_addr={tbl_base, vpage[19:10]}; leave to L1_WAIT on first cycle with i_mem_stall=0.
REQ-007 L1_WAIT: o_mem_stb=0, o_mem_cyc=1; on i_mem_ack latch word L1; L1[0]=0 -> fault 10, else L2_REQ.
REQ-008 L2_REQ/L2_WAIT SHALL mirror REQ-006/007 with o_mem_addr={L1[31:12], vpage[9:0]}; L2[0]=0 -> fault 11, else WR_V.
REQ-009 o_mem_cyc SHALL drop for one cycle between L1 and L2 accesses; exactly one stb accepted per level.
REQ-010 i_mem_err while o_mem_cyc=1 (any mem state) -> drop cyc same edge, fault 01; a simultaneous ack is ignored.
REQ-011 WR_V: o_ctl_stb=1, o_ctl_addr={1'b1, slot, 1'b0}, o_ctl_data={vpage, L2[11:0]}; hold until i_ctl_ack, then WR_P.
REQ-012 WR_P: o_ctl_stb=1, o_ctl_addr={1'b1, slot, 1'b1}, o_ctl_data={L2[31:12], context}; on i_ctl_ack -> FIN.
REQ-013 slot SHALL be an LGTBL-bit round-robin counter, incremented modulo 2^LGTBL on WR_P ack; 2^LGTBL-1 wraps to 0.
REQ-014 FIN: o_done=1 one cycle -> IDLE; a fault SHALL set o_fault=1 one cycle, update o_fault_code, -> IDLE, slot unchanged.
REQ-015 Walk latency with zero-stall single-cycle-ack memory and control port: i_miss to o_done = 8 cycles.
REQ-016 o_ctl_stb and o_mem_cyc SHALL never be asserted in the same cycle.

Reset
REQ-017 i_reset_n=0 SHALL asynchronously force IDLE, slot=0, o_fault_code=00, latched registers 0, all outputs 0.
REQ-018 Reset mid-walk SHALL drop o_mem_cyc/o_ctl_stb immediately with no o_done/o_fault pulse; first i_miss after release starts a fresh walk.

Verification
REQ-019 tbl_base=0x00010, miss_addr=0x0000_4C00 (vpage 0x00013), L1@0x0004000=0x00020001, L2@0x0008013=0xABCDE005, ctx=0x123 -> writes 0x080/0x0001300 5 then 0x081/0xABCDE123; o_done at cycle 8; slot=1.
REQ-020 Same walk, L1 word=0x00020000 -> o_fault, code 10, no ctl writes, slot unchanged.
REQ-021 i_mem_err on L2 read -> o_mem_cyc low same edge, o_fault, code 01.
REQ-022 65 consecutive successful walks -> 65th write targets slot 0 (addr 0x080/0x081).
REQ-023 i_mem_stall=1 for 3 cycles in L1_REQ and second i_miss during walk -> address held stable, one stb accepted, second miss dropped, single o_done.
REQ-024 i_reset_n low during WR_V -> o_ctl_stb low immediately, no pulses; next miss walks correctly from slot 0.
